// File: rtl/perf_dump_unit.sv
// perf_dump_unit
//   Counts pipeline performance events while the program runs. When the core
//   signals ecall it freezes the counters and streams out DUMP_WORDS words of
//   data memory followed by the four counters over a valid/ready port.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   lwstall_a/b                   load-use stall flags (two issue slots)
//   branchstall_a/b               stall-before-branch flags
//   stall                         global pipeline stall
//   bra_op_a/b                    branch op present in each slot
//   ecall                         program end; starts the dump
//   mem_addr / mem_rdata          data-memory read port (combinational data)
//   out_data/out_valid/out_ready  streamed word handshake
//   out_last                      marks the final streamed word
//   done                          dump finished; held until reset
module perf_dump_unit #(
  parameter int DUMP_WORDS = 200,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lwstall_a,
  input  logic              lwstall_b,
  input  logic              branchstall_a,
  input  logic              branchstall_b,
  input  logic              stall,
  input  logic              bra_op_a,
  input  logic              bra_op_b,
  input  logic              ecall,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              done
);

  localparam int IDX_W = $clog2(DUMP_WORDS + 4);
  localparam logic [IDX_W-1:0] MEM_END  = IDX_W'(DUMP_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DUMP_WORDS + 3);

  typedef enum logic [1:0] {S_RUN, S_RD, S_TX, S_DONE} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  cyc_q, lw_q, bb_q, ab_q;
  logic [DATA_W-1:0]  data_q;
  logic               valid_q, last_q, done_q;

  logic               is_mem;
  logic [IDX_W-1:0]   cidx;
  logic [DATA_W-1:0]  cnt_word;
  logic [DATA_W-1:0]  word_d;

  assign is_mem = (idx_q < MEM_END);
  assign cidx   = idx_q - MEM_END;

  // Counter words follow the memory words in a fixed order.
  always_comb begin
    cnt_word = cyc_q;
    case (cidx)
      IDX_W'(1): cnt_word = lw_q;
      IDX_W'(2): cnt_word = bb_q;
      IDX_W'(3): cnt_word = ab_q;
      default:   cnt_word = cyc_q;
    endcase
  end

  assign word_d = is_mem ? mem_rdata : cnt_word;

  // Address is only driven while a memory word is being fetched; reset puts
  // the FSM in RUN so this goes to zero immediately with rst.
  assign mem_addr = (state_q == S_RD && is_mem) ? ADDR_W'(idx_q) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      idx_q   <= '0;
      cyc_q   <= '0;
      lw_q    <= '0;
      bb_q    <= '0;
      ab_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (ecall) begin
            // Counters freeze on the ecall edge itself.
            idx_q   <= '0;
            state_q <= S_RD;
          end else begin
            cyc_q <= cyc_q + 1'b1;
            if (lwstall_a | lwstall_b)         lw_q <= lw_q + 1'b1;
            if (branchstall_a | branchstall_b) bb_q <= bb_q + 1'b1;
            if (!stall & (bra_op_a | bra_op_b)) ab_q <= ab_q + 1'b1;
          end
        end
        S_RD: begin
          data_q  <= word_d;
          valid_q <= 1'b1;
          last_q  <= (idx_q == LAST_IDX);
          state_q <= S_TX;
        end
        S_TX: begin
          // Word and last flag hold until the sink takes them.
          if (out_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= S_RD;
            end
          end
        end
        default: begin
          done_q <= 1'b1;
        end
      endcase
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign done      = done_q;

endmodule
